simd_gpu: RTL and testbench

//  Minimal SIMD GPU: NUM_CORES x THREADS_PER_CORE threads run one fixed vector-add kernel in lockstep
//  on a shared on-chip byte memory: C[t] = A[t] + B[t].
//  Top-level compute block: start/done handshake, performance counters and debug taps for system integration.

---
 rtl/simd_gpu.sv | 149 ++++++++++++++
 tb/tb_simd_gpu.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/simd_gpu.sv
// Minimal lockstep SIMD GPU: every thread runs a fixed five-instruction vector-add
// kernel (C[t] = A[t] + B[t]) against a shared on-chip byte memory.
module simd_gpu #(
  parameter int NUM_CORES        = 2,
  parameter int THREADS_PER_CORE = 2,
  parameter int MEM_SIZE         = 32,
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  output logic [31:0]           total_cycles,
  output logic [31:0]           active_cycles,
  output logic [7:0]            pipeline_utilization,
  output logic [15:0]           instructions_completed,
  output logic [DATA_WIDTH-1:0] debug_core0_reg0,
  output logic [DATA_WIDTH-1:0] debug_core1_reg0,
  output logic [DATA_WIDTH-1:0] debug_memory_0,
  output logic [DATA_WIDTH-1:0] debug_memory_16
);

  localparam int N      = NUM_CORES * THREADS_PER_CORE;
  localparam int B_BASE = N;
  localparam int C_BASE = MEM_SIZE / 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] PC_LOAD_A = 3'd0;
  localparam logic [2:0] PC_LOAD_B = 3'd1;
  localparam logic [2:0] PC_ADD    = 3'd2;
  localparam logic [2:0] PC_STORE  = 3'd3;
  localparam logic [2:0] PC_HALT   = 3'd4;

  // State, memory and thread flags are kept as plain named signals so they
  // can be probed hierarchically (dut.state, dut.mem, dut.thread_active).
  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [N-1:0]          thread_active;
  logic [2:0]            pc [N];
  logic [DATA_WIDTH-1:0] r0 [N];
  logic [DATA_WIDTH-1:0] r1 [N];
  logic [DATA_WIDTH-1:0] r2 [N];
  logic [31:0]           stall_cycles;
  logic [31:0]           pipeline_bubbles;

  logic [15:0] active_count;
  logic        any_active;
  logic [16:0] instr_sum;
  logic [39:0] util_num;
  logic [39:0] util_den;
  logic [39:0] util_quot;
  logic [7:0]  util_next;

  always_comb begin
    active_count = '0;
    for (int i = 0; i < N; i++) begin
      active_count = active_count + 16'(thread_active[i]);
    end
    any_active = |thread_active;
    instr_sum  = {1'b0, instructions_completed} + {1'b0, active_count};
  end

  // Stalls and bubbles would lengthen the issue window, so they widen the denominator.
  always_comb begin
    util_num  = 40'(instructions_completed) * 40'd100;
    util_den  = (40'(total_cycles) + 40'(stall_cycles) + 40'(pipeline_bubbles)) * 40'(N);
    util_quot = (util_den == '0) ? '0 : util_num / util_den;
    util_next = (util_quot > 40'd100) ? 8'd100 : util_quot[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= ST_IDLE;
      done                   <= 1'b0;
      total_cycles           <= '0;
      active_cycles          <= '0;
      instructions_completed <= '0;
      pipeline_utilization   <= '0;
      stall_cycles           <= '0;
      pipeline_bubbles       <= '0;
      thread_active          <= '0;
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem[i] <= (i < 2 * N) ? DATA_WIDTH'(i + 1) : '0;
      end
      for (int t = 0; t < N; t++) begin
        pc[t] <= PC_LOAD_A;
        r0[t] <= '0;
        r1[t] <= '0;
        r2[t] <= '0;
      end
    end else begin
      pipeline_utilization <= util_next;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state                  <= ST_RUN;
            done                   <= 1'b0;
            total_cycles           <= '0;
            active_cycles          <= '0;
            instructions_completed <= '0;
            pipeline_utilization   <= '0;
            stall_cycles           <= '0;
            pipeline_bubbles       <= '0;
            thread_active          <= '1;
            for (int t = 0; t < N; t++) begin
              pc[t] <= PC_LOAD_A;
            end
          end
        end
        ST_RUN: begin
          if (any_active) begin
            total_cycles           <= (total_cycles == '1) ? total_cycles : total_cycles + 32'd1;
            active_cycles          <= (active_cycles == '1) ? active_cycles : active_cycles + 32'd1;
            instructions_completed <= instr_sum[16] ? 16'hFFFF : instr_sum[15:0];
            // Ascending tid order: on an address collision the highest tid's store lands last.
            for (int t = 0; t < N; t++) begin
              if (thread_active[t]) begin
                case (pc[t])
                  PC_LOAD_A: r1[t] <= mem[ADDR_WIDTH'(t)];
                  PC_LOAD_B: r2[t] <= mem[ADDR_WIDTH'(B_BASE + t)];
                  PC_ADD:    r0[t] <= r1[t] + r2[t];
                  PC_STORE:  mem[ADDR_WIDTH'(C_BASE + t)] <= r0[t];
                  default:   thread_active[t] <= 1'b0;
                endcase
                if (pc[t] != PC_HALT) begin
                  pc[t] <= pc[t] + 3'd1;
                end
              end
            end
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign debug_core0_reg0 = r0[0];
  assign debug_core1_reg0 = r0[THREADS_PER_CORE];
  assign debug_memory_0   = mem[0];
  assign debug_memory_16  = mem[16];

endmodule

// File: tb/tb_simd_gpu.sv
// Directed self-checking bench for simd_gpu: reset state, kernel results,
// counters, restart behaviour, arithmetic wrap and mid-run reset.
module tb_simd_gpu;

  logic        clk;
  logic        reset;
  logic        start;
  logic        done;
  logic [31:0] total_cycles;
  logic [31:0] active_cycles;
  logic [7:0]  pipeline_utilization;
  logic [15:0] instructions_completed;
  logic [7:0]  debug_core0_reg0;
  logic [7:0]  debug_core1_reg0;
  logic [7:0]  debug_memory_0;
  logic [7:0]  debug_memory_16;

  int tests_run;
  int tests_failed;

  simd_gpu dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .done                   (done),
    .total_cycles           (total_cycles),
    .active_cycles          (active_cycles),
    .pipeline_utilization   (pipeline_utilization),
    .instructions_completed (instructions_completed),
    .debug_core0_reg0       (debug_core0_reg0),
    .debug_core1_reg0       (debug_core1_reg0),
    .debug_memory_0         (debug_memory_0),
    .debug_memory_16        (debug_memory_16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulses start (or holds it for 'hold' cycles), then counts edges until done.
  task automatic run_kernel(input string tag, input int hold, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold <= 1) start = 1'b0;
    check({tag, "_done_low"}, 64'(done), 64'd0);
    check({tag, "_total_clr"}, 64'(total_cycles), 64'd0);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles + 1 >= hold) start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cycles), 64'd6);
  endtask

  task automatic check_results(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
    check({tag, "_c0"}, 64'(dut.mem[16]), 64'(e0));
    check({tag, "_c1"}, 64'(dut.mem[17]), 64'(e1));
    check({tag, "_c2"}, 64'(dut.mem[18]), 64'(e2));
    check({tag, "_c3"}, 64'(dut.mem[19]), 64'(e3));
    check({tag, "_dbg_m16"}, 64'(debug_memory_16), 64'(e0));
    check({tag, "_dbg_c0r0"}, 64'(debug_core0_reg0), 64'(e0));
    check({tag, "_dbg_c1r0"}, 64'(debug_core1_reg0), 64'(e2));
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_total"}, 64'(total_cycles), 64'd5);
    check({tag, "_active"}, 64'(active_cycles), 64'd5);
    check({tag, "_instr"}, 64'(instructions_completed), 64'd20);
    check({tag, "_util"}, 64'(pipeline_utilization), 64'd100);
  endtask

  initial begin
    int cyc;
    logic [7:0] exp_init;
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_done", 64'(done), 64'd0);
    check("rst_total", 64'(total_cycles), 64'd0);
    check("rst_active", 64'(active_cycles), 64'd0);
    check("rst_instr", 64'(instructions_completed), 64'd0);
    check("rst_util", 64'(pipeline_utilization), 64'd0);
    for (int i = 0; i < 8; i++) begin
      exp_init = 8'(i + 1);
      check($sformatf("rst_mem%0d", i), 64'(dut.mem[i]), 64'(exp_init));
    end
    for (int i = 16; i < 20; i++) begin
      check($sformatf("rst_mem%0d", i), 64'(dut.mem[i]), 64'd0);
    end
    check("rst_dbg_m0", 64'(debug_memory_0), 64'd1);

    // first kernel: C = {1+5, 2+6, 3+7, 4+8}
    run_kernel("run1", 1, cyc);
    check_results("run1", 8'd6, 8'd8, 8'd10, 8'd12);
    check_counters("run1");
    repeat (4) @(posedge clk);
    #1;
    check("run1_done_hold", 64'(done), 64'd1);
    check("run1_total_hold", 64'(total_cycles), 64'd5);

    // start held high through most of RUN: no restart
    run_kernel("held", 5, cyc);
    check_results("held", 8'd6, 8'd8, 8'd10, 8'd12);
    check_counters("held");
    repeat (3) @(posedge clk);
    #1;
    check("held_done_after", 64'(done), 64'd1);

    // wrap: 250 + 10 = 260 -> 4
    @(negedge clk);
    dut.mem[0] = 8'd250;
    dut.mem[4] = 8'd10;
    run_kernel("wrap", 1, cyc);
    check_results("wrap", 8'd4, 8'd8, 8'd10, 8'd12);
    check_counters("wrap");

    // reset mid-run restores initial memory and idle state
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_running", 64'(done), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_total", 64'(total_cycles), 64'd0);
    check("mrst_instr", 64'(instructions_completed), 64'd0);
    check("mrst_mem0", 64'(dut.mem[0]), 64'd1);
    check("mrst_mem4", 64'(dut.mem[4]), 64'd5);
    check("mrst_mem16", 64'(dut.mem[16]), 64'd0);
    check("mrst_active", 64'(dut.thread_active), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mrst_idle_done", 64'(done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
